// File: rtl/pipe_stage_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core, steered
// by the hazard unit's StallF/StallD/FlushE, with saturating stall/flush event counters.
module pipe_stage_regs #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int                CTRL_W   = 9,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic [WIDTH-1:0]  PCBranchD,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  SignImmD,
  output logic [WIDTH-1:0]  PCF,
  output logic [WIDTH-1:0]  PCPlus4F,
  output logic [31:0]       InstrD,
  output logic [WIDTH-1:0]  PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [WIDTH-1:0]  RD1E,
  output logic [WIDTH-1:0]  RD2E,
  output logic [WIDTH-1:0]  SignImmE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
  endfunction

  logic [WIDTH-1:0]  pcf_q, pcf_d;
  logic [31:0]       instr_d_q, instr_d_d;
  logic [WIDTH-1:0]  pc4_d_q, pc4_d_d;
  logic              vld_d_q, vld_d_d;
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic [WIDTH-1:0]  rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d, imm_e_q, imm_e_d;
  logic [4:0]        rs_e_q, rs_e_d, rt_e_q, rt_e_d, rd_e_q, rd_e_d;
  logic              vld_e_q, vld_e_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              flush_evt;

  assign PCPlus4F = pcf_q + WIDTH'(4);
  // A squash blocked by StallD is the branch-stall case and is not an event.
  assign flush_evt = (PCSrcD && !StallD) || FlushE;

  always_comb begin
    // Fetch stage: StallF outranks a taken branch.
    pcf_d = StallF ? pcf_q : (PCSrcD ? PCBranchD : PCPlus4F);

    // IF/ID stage
    instr_d_d = instr_d_q;
    pc4_d_d   = pc4_d_q;
    vld_d_d   = vld_d_q;
    if (!StallD) begin
      if (PCSrcD) begin
        instr_d_d = '0;
        pc4_d_d   = '0;
        vld_d_d   = 1'b0;
      end else begin
        instr_d_d = InstrF;
        pc4_d_d   = PCPlus4F;
        vld_d_d   = 1'b1;
      end
    end

    // ID/EX stage
    ctrl_e_d = vld_d_q ? CtrlD : '0;
    rd1_e_d  = RD1D;
    rd2_e_d  = RD2D;
    imm_e_d  = SignImmD;
    rs_e_d   = instr_d_q[25:21];
    rt_e_d   = instr_d_q[20:16];
    rd_e_d   = instr_d_q[15:11];
    vld_e_d  = vld_d_q;
    if (FlushE) begin
      ctrl_e_d = '0;
      rd1_e_d  = '0;
      rd2_e_d  = '0;
      imm_e_d  = '0;
      rs_e_d   = '0;
      rt_e_d   = '0;
      rd_e_d   = '0;
      vld_e_d  = 1'b0;
    end

    stall_cnt_d = sat_inc(stall_cnt_q, StallF);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_evt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q       <= RESET_PC;
      instr_d_q   <= '0;
      pc4_d_q     <= '0;
      vld_d_q     <= 1'b0;
      ctrl_e_q    <= '0;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      imm_e_q     <= '0;
      rs_e_q      <= '0;
      rt_e_q      <= '0;
      rd_e_q      <= '0;
      vld_e_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instr_d_q   <= instr_d_d;
      pc4_d_q     <= pc4_d_d;
      vld_d_q     <= vld_d_d;
      ctrl_e_q    <= ctrl_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      imm_e_q     <= imm_e_d;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      rd_e_q      <= rd_e_d;
      vld_e_q     <= vld_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF        = pcf_q;
  assign InstrD     = instr_d_q;
  assign PCPlus4D   = pc4_d_q;
  assign ValidD     = vld_d_q;
  assign CtrlE      = ctrl_e_q;
  assign RD1E       = rd1_e_q;
  assign RD2E       = rd2_e_q;
  assign SignImmE   = imm_e_q;
  assign RsE        = rs_e_q;
  assign RtE        = rt_e_q;
  assign RdE        = rd_e_q;
  assign ValidE     = vld_e_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Consumes the stall/flush controls produced by the hazard unit and applies them to the fetch PC, the IF/ID register and the ID/EX register of the 5-stage MIPS pipeline.
- It is the receiving end of StallF/StallD/FlushE. It also produces the RsE/RtE fields that the hazard unit reads back.
- Carries saturating stall and flush event counters for performance debug.

Parameters:
- WIDTH, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 9, width of the decoded control bundle (RegWrite, MemtoReg, MemWrite, MemRead, ALUControl[2:0], ALUSrc, RegDst).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlushE  in  1  bubble into ID/EX
- PCSrcD  in  1  branch taken, resolved in decode
- PCBranchD  in  WIDTH  branch target
- InstrF  in  32  instruction-memory read data at PCF
- CtrlD  in  CTRL_W  decoded controls for InstrD
- RD1D, RD2D  in  WIDTH  register-file read data (post-ForwardAD/BD mux)
- SignImmD  in  WIDTH  sign-extended immediate
- PCF  out  WIDTH  fetch PC
- PCPlus4F  out  WIDTH  PCF+4, combinational
- InstrD  out  32  IF/ID instruction
- PCPlus4D  out  WIDTH  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction
- CtrlE  out  CTRL_W  ID/EX controls
- RD1E, RD2E, SignImmE  out  WIDTH  ID/EX data
- RsE, RtE, RdE  out  5  ID/EX register fields
- ValidE  out  1  ID/EX holds a real instruction
- StallCount  out  CNT_W  cycles with StallF=1
- FlushCount  out  CNT_W  squash/bubble events

Behaviour:
- Reset (asynchronous, active-high): all registers clear immediately, independent of clk.
  - PCF=RESET_PC.
  - InstrD, PCPlus4D, CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidD, ValidE, StallCount and FlushCount all =0.
  - Reset asserted mid-operation discards all in-flight state.
- PCPlus4F = PCF + 4, modulo 2^WIDTH; wrap at all-ones with no flag.
- PC, per edge:
  - StallF=1: hold. This has priority over PCSrcD.
  - Otherwise PCSrcD=1: PCF <= PCBranchD.
  - Otherwise: PCF <= PCPlus4F.
- IF/ID, per edge:
  - StallD=1: hold all fields, including ValidD.
  - Otherwise PCSrcD=1: squash. InstrD <= 0 (nop), PCPlus4D <= 0, ValidD <= 0.
  - Otherwise: InstrD <= InstrF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- ID/EX, per edge (no stall input):
  - FlushE=1: CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE <= 0 and ValidE <= 0.
  - Otherwise: CtrlE <= ValidD ? CtrlD : 0. ValidE <= ValidD. RD1E/RD2E/SignImmE load their D-stage inputs.
  - Field extraction: RsE <= InstrD[25:21], RtE <= InstrD[20:16], RdE <= InstrD[15:11].
- Latency: an instruction fetched at edge n appears on InstrD after edge n+1 and in ID/EX after edge n+2, absent stalls.
- StallF/StallD mismatch: the hazard unit drives them equal, but each register obeys only its own control.
  - StallF=0 with StallD=1: the PC advances while IF/ID holds, so the fetched word is dropped.
- Simultaneous StallD=1, FlushE=1, PCSrcD=1 (normal branch stall):
  - PC holds and IF/ID holds.
  - ID/EX bubbles.
  - No squash is counted.
- StallCount: +1 on each edge with StallF=1. Saturates at 2^CNT_W-1, with no wrap.
- FlushCount: +1 on each edge where (PCSrcD && !StallD) || FlushE. A cycle with both events counts once. Saturates at 2^CNT_W-1.
- All outputs are registered, except PCPlus4F.

Test Plan:
- Release reset with memory returning InstrF=PCF, no stalls → PCF 0,4,8,12 on successive edges; after the 3rd edge InstrD=0x8, ValidD=1, ValidE=1, counters=0.
- Mid-stream, pulse StallF=StallD=FlushE=1 for one cycle with PCF=0x10 → PCF stays 0x10, InstrD unchanged, CtrlE=0, ValidE=0, StallCount=1, FlushCount=1; flow resumes next cycle.
- PCSrcD=1, PCBranchD=0x40, stalls low, at PCF=0x14 → next PCF=0x40, InstrD=0, ValidD=0, FlushCount+1; on the following edge CtrlE=0 and ValidE=0.
- InstrD=0x012A4020 (add $8,$9,$10), CtrlD=9'h1A5, no flush → after one edge RsE=9, RtE=10, RdE=8, CtrlE=9'h1A5.
- CNT_W=4, hold StallF=1 for 20 cycles → StallCount reaches 15 and stays 15; PCF stays constant throughout.
- Assert reset between clock edges while pipeline is full → all outputs at reset values before the next edge; PCF=RESET_PC.
